// File: rtl/adf_spi_seq_writer.sv
// adf_spi_seq_writer: FIFO-buffered serial register writer for ADF-family PLL/DDS parts.
// Words are shifted MSB-first on spi_clk/spi_data and latched by a rising edge on spi_le.
module adf_spi_seq_writer #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int LE_SETUP   = 2,
    parameter int LE_HIGH    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            flush,
    input  logic                            ovf_clr,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
    output logic                            overflow,
    output logic                            busy,
    output logic                            word_done,
    output logic                            spi_clk,
    output logic                            spi_data,
    output logic                            spi_le
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = $clog2(FIFO_DEPTH + 1);
    localparam int BC_W     = $clog2(DATA_W + 1);
    localparam int MAX_A    = (CLK_DIV > LE_SETUP) ? CLK_DIV : LE_SETUP;
    localparam int MAX_HOLD = (MAX_A > LE_HIGH) ? MAX_A : LE_HIGH;
    localparam int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CLK_LO,
        CLK_HI,
        HOLD,
        GAP
    } state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              push;
    logic              drop;
    logic              pop;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nxt;
    logic [BC_W-1:0]   bit_cnt;
    logic [BC_W-1:0]   bit_cnt_nxt;
    logic              clk_nxt;
    logic              data_nxt;
    logic              le_nxt;
    logic              done_nxt;
    logic              cnt_zero;

    assign full     = (count == LVL_W'(FIFO_DEPTH));
    assign level    = count;
    assign push     = wr_en && !full && !flush;
    assign drop     = wr_en && full && !flush;
    assign busy     = (state != IDLE) || (count != '0);
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // A drop is judged against the pre-pop fill level, so a full FIFO drops even while popping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            spi_clk   <= 1'b1;
            spi_data  <= 1'b0;
            spi_le    <= 1'b1;
            word_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shift     <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            spi_clk   <= clk_nxt;
            spi_data  <= data_nxt;
            spi_le    <= le_nxt;
            word_done <= done_nxt;
        end
    end

    // Each state loads cnt with its duration minus one on entry and leaves when it reaches zero.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        clk_nxt     = spi_clk;
        data_nxt    = spi_data;
        le_nxt      = spi_le;
        done_nxt    = 1'b0;
        pop         = 1'b0;

        if (flush) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            bit_cnt_nxt = '0;
            clk_nxt     = 1'b1;
            data_nxt    = 1'b0;
            le_nxt      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        pop         = 1'b1;
                        shift_nxt   = mem[rd_ptr];
                        bit_cnt_nxt = '0;
                        le_nxt      = 1'b0;
                        cnt_nxt     = CNT_W'(LE_SETUP - 1);
                        state_nxt   = SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        clk_nxt   = 1'b0;
                        data_nxt  = shift[DATA_W-1];
                        cnt_nxt   = CNT_W'(CLK_DIV - 1);
                        state_nxt = CLK_LO;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                CLK_LO: begin
                    if (cnt_zero) begin
                        clk_nxt     = 1'b1;
                        shift_nxt   = {shift[DATA_W-2:0], 1'b0};
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        cnt_nxt     = CNT_W'(CLK_DIV - 1);
                        state_nxt   = CLK_HI;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                CLK_HI: begin
                    if (cnt_zero) begin
                        cnt_nxt = CNT_W'(CLK_DIV - 1);
                        if (bit_cnt == BC_W'(DATA_W)) begin
                            state_nxt = HOLD;
                        end else begin
                            clk_nxt   = 1'b0;
                            data_nxt  = shift[DATA_W-1];
                            state_nxt = CLK_LO;
                        end
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        le_nxt    = 1'b1;
                        data_nxt  = 1'b0;
                        cnt_nxt   = CNT_W'(LE_HIGH - 1);
                        state_nxt = GAP;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adf_spi_seq_writer.sv
// tb_adf_spi_seq_writer: checks the serial writer against frame timing formulas and a word queue model.
// Instance A uses default parameters; instance B uses a narrow, fast configuration.
module tb_adf_spi_seq_writer;

    localparam int DW_A = 32, DEPTH_A = 8, CD_A = 2, LS_A = 2, LH_A = 2;
    localparam int DW_B = 24, DEPTH_B = 4, CD_B = 1, LS_B = 1, LH_B = 3;
    localparam int LOW_A = LS_A + (2 * DW_A + 1) * CD_A;
    localparam int PER_A = LOW_A + LH_A + 1;
    localparam int LOW_B = LS_B + (2 * DW_B + 1) * CD_B;
    localparam int PER_B = LOW_B + LH_B + 1;
    localparam int MAXF  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic            wr_en_a, flush_a, ovf_clr_a;
    logic [DW_A-1:0] wr_data_a;
    logic            full_a, overflow_a, busy_a, word_done_a, spi_clk_a, spi_data_a, spi_le_a;
    logic [$clog2(DEPTH_A+1)-1:0] level_a;

    logic            wr_en_b, flush_b, ovf_clr_b;
    logic [DW_B-1:0] wr_data_b;
    logic            full_b, overflow_b, busy_b, word_done_b, spi_clk_b, spi_data_b, spi_le_b;
    logic [$clog2(DEPTH_B+1)-1:0] level_b;

    adf_spi_seq_writer dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_data(wr_data_a), .flush(flush_a),
        .ovf_clr(ovf_clr_a), .full(full_a), .level(level_a), .overflow(overflow_a),
        .busy(busy_a), .word_done(word_done_a), .spi_clk(spi_clk_a), .spi_data(spi_data_a),
        .spi_le(spi_le_a)
    );

    adf_spi_seq_writer #(
        .DATA_W(DW_B), .FIFO_DEPTH(DEPTH_B), .CLK_DIV(CD_B), .LE_SETUP(LS_B), .LE_HIGH(LH_B)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b), .flush(flush_b),
        .ovf_clr(ovf_clr_b), .full(full_b), .level(level_b), .overflow(overflow_b),
        .busy(busy_b), .word_done(word_done_b), .spi_clk(spi_clk_b), .spi_data(spi_data_b),
        .spi_le(spi_le_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Bus monitor: rebuilds each frame from the pins, timestamped in clk cycles.
    logic le_v[2], sck_v[2], sd_v[2], wd_v[2];
    assign le_v[0] = spi_le_a;   assign le_v[1] = spi_le_b;
    assign sck_v[0] = spi_clk_a; assign sck_v[1] = spi_clk_b;
    assign sd_v[0] = spi_data_a; assign sd_v[1] = spi_data_b;
    assign wd_v[0] = word_done_a; assign wd_v[1] = word_done_b;

    int          cyc = 0;
    logic        prev_le[2], prev_sck[2], in_frame[2];
    logic [31:0] shreg[2];
    int          nbits[2], fall_cyc[2], prev_fall[2], last_rise[2], first_one[2];
    logic [31:0] cap_word[2][MAXF];
    int          cap_bits[2][MAXF], cap_low[2][MAXF], cap_first[2][MAXF], cap_per[2][MAXF];
    int          n_frames[2], n_falls[2], n_done[2], sp_min[2], sp_max[2];

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                prev_le[k]  = 1'b1;
                prev_sck[k] = 1'b1;
                in_frame[k] = 1'b0;
                nbits[k]    = 0;
            end else begin
                if (prev_le[k] && !le_v[k]) begin
                    in_frame[k]  = 1'b1;
                    nbits[k]     = 0;
                    shreg[k]     = '0;
                    first_one[k] = 0;
                    last_rise[k] = -1;
                    fall_cyc[k]  = cyc;
                    if (n_falls[k] > 0 && n_falls[k] < MAXF) cap_per[k][n_falls[k]] = cyc - prev_fall[k];
                    prev_fall[k] = cyc;
                    n_falls[k]   = n_falls[k] + 1;
                end
                if (in_frame[k] && !prev_sck[k] && sck_v[k]) begin
                    shreg[k] = {shreg[k][30:0], sd_v[k]};
                    nbits[k] = nbits[k] + 1;
                    if (sd_v[k] && first_one[k] == 0) first_one[k] = nbits[k];
                    if (last_rise[k] >= 0) begin
                        if (cyc - last_rise[k] < sp_min[k]) sp_min[k] = cyc - last_rise[k];
                        if (cyc - last_rise[k] > sp_max[k]) sp_max[k] = cyc - last_rise[k];
                    end
                    last_rise[k] = cyc;
                end
                if (in_frame[k] && !prev_le[k] && le_v[k]) begin
                    if (n_frames[k] < MAXF) begin
                        cap_word[k][n_frames[k]]  = shreg[k];
                        cap_bits[k][n_frames[k]]  = nbits[k];
                        cap_low[k][n_frames[k]]   = cyc - fall_cyc[k];
                        cap_first[k][n_frames[k]] = first_one[k];
                    end
                    n_frames[k] = n_frames[k] + 1;
                    in_frame[k] = 1'b0;
                end
                if (wd_v[k]) n_done[k] = n_done[k] + 1;
                prev_le[k]  = le_v[k];
                prev_sck[k] = sck_v[k];
            end
        end
    end

    task automatic clearMonitor();
        for (int k = 0; k < 2; k++) begin
            n_frames[k] = 0;
            n_falls[k]  = 0;
            n_done[k]   = 0;
            sp_min[k]   = 1000;
            sp_max[k]   = 0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // One push per call; inputs change just after a falling edge so back-to-back calls are consecutive cycles.
    task automatic applyStimulus(input int which, input logic [31:0] word);
        if (which == 0) begin
            wr_data_a = word[DW_A-1:0];
            wr_en_a   = 1'b1;
            @(negedge clk);
            wr_en_a   = 1'b0;
        end else begin
            wr_data_b = word[DW_B-1:0];
            wr_en_b   = 1'b1;
            @(negedge clk);
            wr_en_b   = 1'b0;
        end
    endtask

    task automatic waitIdle(input int which, input int budget, output logic ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (which == 0 ? (!busy_a && spi_le_a) : (!busy_b && spi_le_b)) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] word;
        int          first_one;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_q[$];
    logic        ok;
    int          n, rises, seen;
    logic        prev;

    initial begin
        vecs[0] = '{word: 32'h0000_0007, first_one: 30};
        vecs[1] = '{word: 32'h8000_0000, first_one: 1};
        vecs[2] = '{word: 32'h0000_0000, first_one: 0};
        vecs[3] = '{word: 32'hFFFF_FFFF, first_one: 1};
        vecs[4] = '{word: 32'h1234_5678, first_one: 4};
        vecs[5] = '{word: 32'h0001_0000, first_one: 16};

        wr_en_a = 0; flush_a = 0; ovf_clr_a = 0; wr_data_a = '0;
        wr_en_b = 0; flush_b = 0; ovf_clr_b = 0; wr_data_b = '0;
        clearMonitor();
        repeat (3) @(negedge clk);
        checkOutput("rst_spi_clk", spi_clk_a, 1);
        checkOutput("rst_spi_data", spi_data_a, 0);
        checkOutput("rst_spi_le", spi_le_a, 1);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_word_done", word_done_a, 0);
        checkOutput("rst_full", full_a, 0);
        checkOutput("rst_level", level_a, 0);
        checkOutput("rst_overflow", overflow_a, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single words from the vector table.
        foreach (vecs[i]) begin
            clearMonitor();
            applyStimulus(0, vecs[i].word);
            waitIdle(0, 400, ok);
            checkOutput($sformatf("tbl%0d_idle", i), ok, 1);
            checkOutput($sformatf("tbl%0d_frames", i), n_frames[0], 1);
            checkOutput($sformatf("tbl%0d_word", i), cap_word[0][0], vecs[i].word);
            checkOutput($sformatf("tbl%0d_rises", i), cap_bits[0][0], DW_A);
            checkOutput($sformatf("tbl%0d_le_low", i), cap_low[0][0], LOW_A);
            checkOutput($sformatf("tbl%0d_first_one", i), cap_first[0][0], vecs[i].first_one);
            checkOutput($sformatf("tbl%0d_done", i), n_done[0], 1);
            checkOutput($sformatf("tbl%0d_sclk_min", i), sp_min[0], 2 * CD_A);
            checkOutput($sformatf("tbl%0d_sclk_max", i), sp_max[0], 2 * CD_A);
            checkOutput($sformatf("tbl%0d_busy", i), busy_a, 0);
        end

        // Random bursts against the word-queue model.
        for (int r = 0; r < 4; r++) begin
            clearMonitor();
            exp_q.delete();
            n = $urandom_range(DEPTH_A, 1);
            for (int j = 0; j < n; j++) begin
                exp_q.push_back($urandom());
                applyStimulus(0, exp_q[j]);
                repeat ($urandom_range(3, 0)) @(negedge clk);
            end
            waitIdle(0, (n + 1) * PER_A + 50, ok);
            checkOutput($sformatf("rnd%0d_idle", r), ok, 1);
            checkOutput($sformatf("rnd%0d_frames", r), n_frames[0], n);
            checkOutput($sformatf("rnd%0d_done", r), n_done[0], n);
            for (int j = 0; j < n; j++) begin
                checkOutput($sformatf("rnd%0d_word%0d", r, j), cap_word[0][j], exp_q[j]);
                checkOutput($sformatf("rnd%0d_low%0d", r, j), cap_low[0][j], LOW_A);
                if (j > 0) checkOutput($sformatf("rnd%0d_per%0d", r, j), cap_per[0][j], PER_A);
            end
        end

        // Burst to full, overflow handling, then push+pop at level DEPTH-1 in IDLE.
        clearMonitor();
        exp_q.delete();
        exp_q.push_back(32'h0000_00C3);
        applyStimulus(0, 32'h0000_00C3);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'h8000_0000 + i);
            applyStimulus(0, 32'h8000_0000 + i);
        end
        checkOutput("burst_full", full_a, 1);
        checkOutput("burst_level", level_a, DEPTH_A);
        checkOutput("burst_ovf_before", overflow_a, 0);
        applyStimulus(0, 32'h8000_00FF);
        checkOutput("drop_overflow", overflow_a, 1);
        checkOutput("drop_level", level_a, DEPTH_A);
        wr_en_a = 1; ovf_clr_a = 1;
        @(negedge clk);
        wr_en_a = 0; ovf_clr_a = 0;
        checkOutput("ovf_set_wins", overflow_a, 1);
        ovf_clr_a = 1;
        @(negedge clk);
        ovf_clr_a = 0;
        checkOutput("ovf_clr", overflow_a, 0);
        seen = 0; ok = 0;
        for (int t = 0; t < 3 * PER_A; t++) begin
            @(negedge clk);
            if (word_done_a) seen++;
            if (seen == 2) begin ok = 1; break; end
        end
        checkOutput("pp_reach_idle", ok, 1);
        checkOutput("pp_level_before", level_a, DEPTH_A - 1);
        exp_q.push_back(32'h0000_0ACE);
        applyStimulus(0, 32'h0000_0ACE);
        checkOutput("pp_level_after", level_a, DEPTH_A - 1);
        checkOutput("pp_no_overflow", overflow_a, 0);
        waitIdle(0, 11 * PER_A + 50, ok);
        checkOutput("burst_idle", ok, 1);
        checkOutput("burst_frames", n_frames[0], exp_q.size());
        checkOutput("burst_done", n_done[0], exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) begin
            checkOutput($sformatf("burst_word%0d", j), cap_word[0][j], exp_q[j]);
            checkOutput($sformatf("burst_low%0d", j), cap_low[0][j], LOW_A);
            if (j > 0) checkOutput($sformatf("burst_per%0d", j), cap_per[0][j], PER_A);
        end

        // Narrow, fast configuration on instance B.
        clearMonitor();
        applyStimulus(1, 32'h00A5_A5A5);
        applyStimulus(1, 32'h005A_5A5A);
        waitIdle(1, 4 * PER_B, ok);
        checkOutput("b_idle", ok, 1);
        checkOutput("b_frames", n_frames[1], 2);
        checkOutput("b_word0", cap_word[1][0], 32'h00A5_A5A5);
        checkOutput("b_word1", cap_word[1][1], 32'h005A_5A5A);
        checkOutput("b_rises0", cap_bits[1][0], DW_B);
        checkOutput("b_low0", cap_low[1][0], LOW_B);
        checkOutput("b_per1", cap_per[1][1], PER_B);
        checkOutput("b_sclk_min", sp_min[1], 2 * CD_B);
        checkOutput("b_sclk_max", sp_max[1], 2 * CD_B);
        checkOutput("b_done", n_done[1], 2);

        // Flush at the 10th SCLK rising edge, with a colliding push.
        clearMonitor();
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0F0F_0000 + i);
        rises = 0; prev = spi_clk_a; ok = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (!prev && spi_clk_a) rises++;
            prev = spi_clk_a;
            if (rises == 10) begin ok = 1; break; end
        end
        checkOutput("flush_edge10", ok, 1);
        flush_a = 1; wr_en_a = 1; wr_data_a = 32'hDEAD_BEEF;
        @(negedge clk);
        flush_a = 0; wr_en_a = 0;
        checkOutput("flush_le", spi_le_a, 1);
        checkOutput("flush_sclk", spi_clk_a, 1);
        checkOutput("flush_data", spi_data_a, 0);
        checkOutput("flush_level", level_a, 0);
        checkOutput("flush_busy", busy_a, 0);
        checkOutput("flush_no_ovf", overflow_a, 0);
        repeat (40) @(negedge clk);
        checkOutput("flush_no_done", n_done[0], 0);
        checkOutput("flush_falls", n_falls[0], 1);
        checkOutput("flush_partial_bits", cap_bits[0][0], 10);
        applyStimulus(0, 32'h1357_9BDF);
        waitIdle(0, 400, ok);
        checkOutput("post_flush_idle", ok, 1);
        checkOutput("post_flush_frames", n_frames[0], 2);
        checkOutput("post_flush_word", cap_word[0][1], 32'h1357_9BDF);
        checkOutput("post_flush_rises", cap_bits[0][1], DW_A);
        checkOutput("post_flush_done", n_done[0], 1);

        // Asynchronous reset between clock edges while in CLK_LO.
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'hC0DE_0000 + i);
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!spi_clk_a) begin ok = 1; break; end
        end
        checkOutput("arst_reach_clk_lo", ok, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_sclk", spi_clk_a, 1);
        checkOutput("arst_le", spi_le_a, 1);
        checkOutput("arst_data", spi_data_a, 0);
        checkOutput("arst_busy", busy_a, 0);
        checkOutput("arst_level", level_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clearMonitor();
        repeat (400) @(negedge clk);
        checkOutput("arst_no_residual", n_falls[0], 0);
        checkOutput("arst_idle_busy", busy_a, 0);
        applyStimulus(0, 32'h2468_ACE0);
        waitIdle(0, 400, ok);
        checkOutput("arst_after_word", cap_word[0][0], 32'h2468_ACE0);
        checkOutput("arst_after_frames", n_frames[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
